scn4m_subm_16x2_arb: RTL and testbench
======================================

Name: scn4m_subm_16x2_arb

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 16x2 OpenRAM macro.
- Owns the macro's RW port (csb0/web0/addr0/din0) and captures dout0 at the correct edge.
- Returns read data to the requester that issued the read, with a fixed 2-cycle latency.
- After reset, optionally sweeps the whole array with an init value before accepting traffic.

Parameters:
- DATA_WIDTH, 2, macro word width.
- ADDR_WIDTH, 4, macro address width; depth = 1<<ADDR_WIDTH.
- INIT_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN.
- INIT_VALUE, 2'b00, word written to every address during the sweep.

Ports:
- clk0  in  1  clock; same clock as the macro's clk0.
- rstb0  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an access pending.
- req0_ready  out  1  requester 0 access accepted this cycle.
- req0_web  in  1  0 = write, 1 = read.
- req0_addr  in  ADDR_WIDTH  access address.
- req0_din  in  DATA_WIDTH  write data.
- rsp0_valid  out  1  one-cycle pulse; rsp0_dout is valid.
- rsp0_dout  out  DATA_WIDTH  read data for requester 0.
- req1_valid, req1_ready, req1_web, req1_addr, req1_din, rsp1_valid, rsp1_dout: same as the port-0 signals, for requester 1.
- init_done  out  1  high once the sweep completes (or at the first RUN cycle if INIT_ON_RESET=0).
- sram_csb0  out  1  macro chip select, active low; registered.
- sram_web0  out  1  macro write enable, active low; registered.
- sram_addr0  out  ADDR_WIDTH  macro address; registered.
- sram_din0  out  DATA_WIDTH  macro write data; registered.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset state while rstb0=0 at a posedge:
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - req*_ready=0, rsp*_valid=0, rsp*_dout=0, init_done=0.
  - rr_ptr=1, so requester 0 wins the first conflict.
  - Pipeline tags cleared, so in-flight reads are discarded (no response).
  - Next state is INIT if INIT_ON_RESET=1, else RUN.
- INIT state:
  - Counter runs 0..DEPTH-1, one write per cycle: sram_csb0=0, sram_web0=0, sram_addr0=cnt, sram_din0=INIT_VALUE.
  - req*_ready=0 throughout.
  - After the cycle issuing address DEPTH-1, go to RUN; init_done rises with RUN.
  - Sweep takes exactly DEPTH cycles (16 at default).
- RUN state, grant logic (combinational from req*_valid and rr_ptr):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != rr_ptr.
  - req*_ready = grant. At most one ready per cycle.
  - Accepted access (valid && ready at posedge T0): rr_ptr updates to the granted index.
- RUN state, macro drive:
  - At T0: sram_csb0=0, sram_web0=req_web, sram_addr0=req_addr, sram_din0=req_din.
  - No grant: sram_csb0=1; other sram_* hold.
  - Macro samples at T1 and performs the access at the negedge after T1.
- Read pipeline:
  - At T0 the requester id and read flag are tagged.
  - At T1 the tag moves to stage 2.
  - At T2 sram_dout0 is captured into rsp<id>_dout and rsp<id>_valid pulses for the cycle after T2.
  - Read latency is 2 cycles from acceptance to the response-valid cycle.
- Throughput: one access per cycle, back-to-back, any read/write mix.
- A write followed by a read of the same address in the next cycle returns the new data (the macro writes at the negedge before the next sample).
- Writes produce no response.
- rsp*_dout holds its last value when rsp*_valid=0.
- Timing: capture occurs at the posedge, before the macro's T_HOLD x-out. Clock period must be >= 2*(DELAY+1) time units; the bench uses 10.
- Reset mid-sweep or mid-read: abort immediately to the reset state, and re-run the sweep from address 0.

Test Plan:
- Reset then release, INIT_ON_RESET=1, INIT_VALUE=2'b00 -> 16 consecutive writes, addr 0..15, din=00; req*_ready=0 throughout; init_done=1 on the 17th cycle; a following read of addr 9 returns 00.
- Req0 writes addr 3 = 2'b10, next cycle req0 reads addr 3 -> rsp0_valid pulses 2 cycles after the read is accepted, rsp0_dout=10; rsp1_valid stays 0.
- Both requesters assert valid continuously, each doing reads -> grants alternate 0,1,0,1; csb0=0 every cycle; responses alternate rsp0/rsp1, each with 2-cycle latency.
- Req1 reads addr 15 while req0 idles, then rstb0 is pulled low the cycle after acceptance -> no rsp1_valid; sram_csb0=1; the sweep restarts from addr 0 after release.
- INIT_ON_RESET=0 -> init_done=1 and req0_ready possible in the first cycle after reset release; no write cycles are issued.
- Back-to-back: req0 write addr 5 = 11, req1 read addr 5 in the next cycle -> rsp1_dout=11.

Source files
------------

// File: rtl/scn4m_subm_16x2_arb.sv
// rtl/scn4m_subm_16x2_arb.sv - two-requester round-robin arbiter and sequencer for the 16x2 single-port macro
module scn4m_subm_16x2_arb #(
    parameter int                    DATA_WIDTH    = 2,
    parameter int                    ADDR_WIDTH    = 4,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_web,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_din,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_dout,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_web,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_din,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_dout,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    rr_ptr;
    logic                    grant0;
    logic                    grant1;
    logic                    accept;
    logic                    grant_id;
    logic                    sel_web;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic                    s1_rd;
    logic                    s1_id;
    logic                    s2_rd;
    logic                    s2_id;

    // rr_ptr names the last winner; on a conflict the other requester goes next
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (state == ST_INIT) begin
            if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end else begin
            if (req0_valid && req1_valid) begin
                grant0 = rr_ptr;
                grant1 = !rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0 && rstb0;
    assign req1_ready = grant1 && rstb0;
    assign accept     = req0_ready || req1_ready;
    assign grant_id   = req1_ready;
    assign init_done  = (state == ST_RUN) && rstb0;

    always_comb begin
        sel_web  = req0_web;
        sel_addr = req0_addr;
        sel_din  = req0_din;
        if (grant_id) begin
            sel_web  = req1_web;
            sel_addr = req1_addr;
            sel_din  = req1_din;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state      <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt        <= '0;
            rr_ptr     <= 1'b1;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            s1_rd      <= 1'b0;
            s1_id      <= 1'b0;
            s2_rd      <= 1'b0;
            s2_id      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_dout  <= '0;
            rsp1_dout  <= '0;
        end else begin
            state      <= state_next;
            s1_rd      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (state == ST_INIT) begin
                cnt        <= cnt + 1'b1;
                sram_csb0  <= 1'b0;
                sram_web0  <= 1'b0;
                sram_addr0 <= cnt;
                sram_din0  <= INIT_VALUE;
            end else if (accept) begin
                rr_ptr     <= grant_id;
                sram_csb0  <= 1'b0;
                sram_web0  <= sel_web;
                sram_addr0 <= sel_addr;
                sram_din0  <= sel_din;
                s1_rd      <= sel_web;
                s1_id      <= grant_id;
            end else begin
                sram_csb0  <= 1'b1;
            end
            s2_rd <= s1_rd;
            s2_id <= s1_id;
            // macro has driven dout0 at the negedge after it sampled the read
            if (s2_rd) begin
                if (s2_id) begin
                    rsp1_valid <= 1'b1;
                    rsp1_dout  <= sram_dout0;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_dout  <= sram_dout0;
                end
            end
        end
    end

endmodule

// File: tb/tb_scn4m_subm_16x2_arb.sv
// tb/tb_scn4m_subm_16x2_arb.sv - self-checking bench for scn4m_subm_16x2_arb
module tb_scn4m_subm_16x2_arb;

    logic       clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic       rstb0;
    logic       req0_valid, req0_ready, req0_web, rsp0_valid;
    logic [3:0] req0_addr;
    logic [1:0] req0_din, rsp0_dout;
    logic       req1_valid, req1_ready, req1_web, rsp1_valid;
    logic [3:0] req1_addr;
    logic [1:0] req1_din, rsp1_dout;
    logic       init_done, sram_csb0, sram_web0;
    logic [3:0] sram_addr0;
    logic [1:0] sram_din0;
    logic [1:0] sram_dout0 = 2'b00;

    scn4m_subm_16x2_arb u_dut (
        .clk0(clk0), .rstb0(rstb0),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_web(req0_web),
        .req0_addr(req0_addr), .req0_din(req0_din), .rsp0_valid(rsp0_valid), .rsp0_dout(rsp0_dout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_web(req1_web),
        .req1_addr(req1_addr), .req1_din(req1_din), .rsp1_valid(rsp1_valid), .rsp1_dout(rsp1_dout),
        .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    logic       n_rstb, n_req0_valid, n_req0_ready, n_req0_web, n_rsp0_valid;
    logic [3:0] n_req0_addr;
    logic [1:0] n_req0_din, n_rsp0_dout;
    logic       n_req1_valid, n_req1_ready, n_req1_web, n_rsp1_valid;
    logic [3:0] n_req1_addr;
    logic [1:0] n_req1_din, n_rsp1_dout;
    logic       n_init_done, n_csb, n_web;
    logic [3:0] n_addr;
    logic [1:0] n_din;
    logic [1:0] n_dout = 2'b00;

    scn4m_subm_16x2_arb #(.INIT_ON_RESET(1'b0)) u_dut_noinit (
        .clk0(clk0), .rstb0(n_rstb),
        .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_web(n_req0_web),
        .req0_addr(n_req0_addr), .req0_din(n_req0_din), .rsp0_valid(n_rsp0_valid), .rsp0_dout(n_rsp0_dout),
        .req1_valid(n_req1_valid), .req1_ready(n_req1_ready), .req1_web(n_req1_web),
        .req1_addr(n_req1_addr), .req1_din(n_req1_din), .rsp1_valid(n_rsp1_valid), .rsp1_dout(n_rsp1_dout),
        .init_done(n_init_done), .sram_csb0(n_csb), .sram_web0(n_web),
        .sram_addr0(n_addr), .sram_din0(n_din), .sram_dout0(n_dout)
    );

    // macro model: samples the RW port at posedge, acts at the following negedge
    logic [1:0] mem_arr [16];
    logic       m_csb = 1'b1, m_web = 1'b1;
    logic [3:0] m_addr = 4'd0;
    logic [1:0] m_din = 2'd0;
    always @(posedge clk0) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end
    always @(negedge clk0) begin
        if (!m_csb) begin
            if (!m_web) mem_arr[m_addr] <= m_din;
            else        sram_dout0      <= mem_arr[m_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic v0; logic w0; logic [3:0] a0; logic [1:0] d0;
        logic v1; logic w1; logic [3:0] a1; logic [1:0] d1;
        logic r0; logic r1; logic rv0; logic rv1; logic [1:0] q0; logic [1:0] q1;
    } vec_t;

    typedef struct {
        int         due;
        int         id;
        logic [1:0] data;
    } pend_t;

    function automatic vec_t idle_row(logic rv0, logic rv1, logic [1:0] q0, logic [1:0] q1);
        vec_t r;
        r = '{1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, rv0, rv1, q0, q1};
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk0);
        #1;
    endtask

    vec_t       tbl [19];
    pend_t      pend [$];
    logic [1:0] mem_m [16];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 2'b01;
        rstb0 = 1'b0; n_rstb = 1'b0;
        req0_valid = 1'b0; req0_web = 1'b1; req0_addr = 4'd0; req0_din = 2'd0;
        req1_valid = 1'b0; req1_web = 1'b1; req1_addr = 4'd0; req1_din = 2'd0;
        n_req0_valid = 1'b1; n_req0_web = 1'b1; n_req0_addr = 4'd2; n_req0_din = 2'd0;
        n_req1_valid = 1'b0; n_req1_web = 1'b1; n_req1_addr = 4'd0; n_req1_din = 2'd0;
        repeat (3) @(posedge clk0);
        #1;

        @(negedge clk0);
        chk("rst_csb", 32'(sram_csb0), 32'(1));
        chk("rst_web", 32'(sram_web0), 32'(1));
        chk("rst_addr", 32'(sram_addr0), 32'(0));
        chk("rst_din", 32'(sram_din0), 32'(0));
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
        chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_dout, rsp1_dout}), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        chk("noinit_rst_ready", 32'(n_req0_ready), 32'(0));
        chk("noinit_rst_done", 32'(n_init_done), 32'(0));
        next_cycle();
        n_rstb = 1'b1;
        @(negedge clk0);
        chk("noinit_done_first", 32'(n_init_done), 32'(1));
        chk("noinit_ready_first", 32'(n_req0_ready), 32'(1));
        chk("noinit_no_write", 32'(n_csb), 32'(1));
        next_cycle();
        n_req0_valid = 1'b0;
        @(negedge clk0);
        chk("noinit_csb_read", 32'(n_csb), 32'(0));
        chk("noinit_web_read", 32'(n_web), 32'(1));

        // sweep: requests held high must not be accepted
        next_cycle();
        rstb0 = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int w = 0; w <= 16; w++) begin
            @(negedge clk0);
            chk($sformatf("sweep_done_w%0d", w), 32'(init_done), 32'(w == 16));
            if (w < 16) chk($sformatf("sweep_ready_w%0d", w), 32'({req0_ready, req1_ready}), 32'(0));
            if (w == 0) begin
                chk("sweep_idle_csb", 32'(sram_csb0), 32'(1));
            end else begin
                chk($sformatf("sweep_csb_w%0d", w), 32'(sram_csb0), 32'(0));
                chk($sformatf("sweep_web_w%0d", w), 32'(sram_web0), 32'(0));
                chk($sformatf("sweep_addr_w%0d", w), 32'(sram_addr0), 32'(w - 1));
                chk($sformatf("sweep_din_w%0d", w), 32'(sram_din0), 32'(0));
            end
            next_cycle();
            if (w == 15) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end

        tbl[0]  = '{1'b1, 1'b0, 4'd3, 2'd2, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'd3, 2'd0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 4'd5, 2'd0, 1'b1, 1'b1, 4'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[3]  = '{1'b1, 1'b1, 4'd9, 2'd0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 4'd5, 2'd3, 1'b1, 1'b1, 4'd5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 4'd5, 2'd3, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2};
        tbl[6]  = '{1'b0, 1'b1, 4'd0, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[7]  = idle_row(1'b0, 1'b1, 2'd0, 2'd0);
        tbl[8]  = idle_row(1'b0, 1'b0, 2'd0, 2'd0);
        tbl[9]  = idle_row(1'b0, 1'b1, 2'd0, 2'd3);
        tbl[10] = idle_row(1'b0, 1'b0, 2'd0, 2'd0);
        tbl[11] = '{1'b1, 1'b1, 4'd3, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[12] = '{1'b1, 1'b1, 4'd3, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[13] = '{1'b1, 1'b1, 4'd3, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[14] = '{1'b1, 1'b1, 4'd3, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        tbl[15] = idle_row(1'b0, 1'b1, 2'd0, 2'd3);
        tbl[16] = idle_row(1'b1, 1'b0, 2'd2, 2'd0);
        tbl[17] = idle_row(1'b0, 1'b1, 2'd0, 2'd3);
        tbl[18] = idle_row(1'b0, 1'b0, 2'd0, 2'd0);

        for (int i = 0; i < 19; i++) begin
            req0_valid = tbl[i].v0; req0_web = tbl[i].w0; req0_addr = tbl[i].a0; req0_din = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_web = tbl[i].w1; req1_addr = tbl[i].a1; req1_din = tbl[i].d1;
            @(negedge clk0);
            chk($sformatf("tbl%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(tbl[i].rv0));
            chk($sformatf("tbl%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(tbl[i].rv1));
            if (tbl[i].rv0) chk($sformatf("tbl%0d_rsp0_dout", i), 32'(rsp0_dout), 32'(tbl[i].q0));
            if (tbl[i].rv1) chk($sformatf("tbl%0d_rsp1_dout", i), 32'(rsp1_dout), 32'(tbl[i].q1));
            next_cycle();
        end

        // reset the cycle after a read is accepted: response dropped, sweep restarts
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_web = 1'b1; req1_addr = 4'd15;
        @(negedge clk0);
        chk("abort_ready1", 32'(req1_ready), 32'(1));
        next_cycle();
        req1_valid = 1'b0; rstb0 = 1'b0;
        @(negedge clk0);
        chk("abort_csb_issued", 32'(sram_csb0), 32'(0));
        next_cycle();
        rstb0 = 1'b1;
        @(negedge clk0);
        chk("abort_csb_reset", 32'(sram_csb0), 32'(1));
        chk("abort_rsp1", 32'(rsp1_valid), 32'(0));
        chk("abort_done", 32'(init_done), 32'(0));
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk0);
            chk($sformatf("resweep_addr%0d", k), 32'({sram_csb0, sram_web0, sram_addr0}), 32'(k));
            chk($sformatf("resweep_rsp1_%0d", k), 32'(rsp1_valid), 32'(0));
            chk($sformatf("resweep_done%0d", k), 32'(init_done), 32'(k == 15));
            next_cycle();
        end

        // randomized traffic against a transaction-level model
        begin
            int         last_win = 1;
            logic       prev_acc = 1'b0;
            logic [1:0] last_d0 = 2'd0, last_d1 = 2'd0;
            for (int i = 0; i < 16; i++) mem_m[i] = 2'd0;
            for (int n = 0; n < 400; n++) begin
                int   g;
                logic ev0, ev1;
                req0_valid = ($urandom_range(0, 3) != 0);
                req1_valid = ($urandom_range(0, 3) != 0);
                req0_web   = 1'($urandom_range(0, 1));
                req1_web   = 1'($urandom_range(0, 1));
                req0_addr  = 4'($urandom_range(0, 15));
                req1_addr  = 4'($urandom_range(0, 15));
                req0_din   = 2'($urandom_range(0, 3));
                req1_din   = 2'($urandom_range(0, 3));
                if (req0_valid && req1_valid) g = 1 - last_win;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
                else                          g = -1;
                ev0 = 1'b0; ev1 = 1'b0;
                while (pend.size() > 0 && pend[0].due == n) begin
                    if (pend[0].id == 0) begin ev0 = 1'b1; last_d0 = pend[0].data; end
                    else                 begin ev1 = 1'b1; last_d1 = pend[0].data; end
                    void'(pend.pop_front());
                end
                @(negedge clk0);
                chk("rnd_ready0", 32'(req0_ready), 32'(g == 0));
                chk("rnd_ready1", 32'(req1_ready), 32'(g == 1));
                chk("rnd_csb", 32'(sram_csb0), 32'(!prev_acc));
                chk("rnd_rsp0_valid", 32'(rsp0_valid), 32'(ev0));
                chk("rnd_rsp1_valid", 32'(rsp1_valid), 32'(ev1));
                chk("rnd_rsp0_dout", 32'(rsp0_dout), 32'(last_d0));
                chk("rnd_rsp1_dout", 32'(rsp1_dout), 32'(last_d1));
                prev_acc = (g >= 0);
                if (g >= 0) begin
                    logic       w;
                    logic [3:0] a;
                    logic [1:0] d;
                    last_win = g;
                    w = (g == 0) ? req0_web : req1_web;
                    a = (g == 0) ? req0_addr : req1_addr;
                    d = (g == 0) ? req0_din : req1_din;
                    if (!w) mem_m[a] = d;
                    else    pend.push_back('{n + 3, g, mem_m[a]});
                end
                next_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
